// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as the arithmetic core of serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output OVF.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             C2
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, result_q, result_d, f_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c2_d, busy_d, done_d;
  logic             sum_c, cout_c;

  fa_cell u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (sum_c),
    .co (cout_c)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_d;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    f_d      = F;
    c2_d     = C2;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = OVF;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sa_d     = A;
          sb_d     = B;
          carry_d  = C1;
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = {sum_c, result_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        carry_d  = cout_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          f_d     = result_d;
          c2_d    = cout_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry entering the MSB position
          ovf_d   = carry_q ^ cout_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      F        <= '0;
      C2       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      F        <= f_d;
      C2       <= c2_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      OVF      <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, C1;
  logic [W-1:0] A, B, F;
  logic         busy, done, C2;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .C1    (C1),
    .busy  (busy),
    .done  (done),
    .F     (F),
    .C2    (C2)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands and start, then take the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    A = a; B = b; C1 = c; start = 1'b1;
    tick();
    start = 1'b0;
    A = '1; B = '1; C1 = 1'b1;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Count edges until done, checking busy along the way; bounded.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (!done) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; C1 = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_F", 32'(F), 32'h00);
    chk("rst_C2", 32'(C2), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    launch(8'h00, 8'h00, 1'b0);
    wait_done("zero");
    chk("zero_F", 32'(F), 32'h00);
    chk("zero_C2", 32'(C2), 32'd0);
    tick();
    chk("done_pulse_one_cycle", 32'(done), 32'd0);
    chk("F_held_idle", 32'(F), 32'h00);

    launch(8'hFF, 8'h01, 1'b0);
    wait_done("ff01");
    chk("ff01_F", 32'(F), 32'h00);
    chk("ff01_C2", 32'(C2), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ff01_OVF", 32'(OVF), 32'd0);
`endif
    tick();
    chk("ff01_C2_held", 32'(C2), 32'd1);

    launch(8'h7F, 8'h01, 1'b0);
    wait_done("7f01");
    chk("7f01_F", 32'(F), 32'h80);
    chk("7f01_C2", 32'(C2), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("7f01_OVF", 32'(OVF), 32'd1);
`endif
    tick();

    // Back-to-back: start held during the DONE cycle.
    launch(8'hA5, 8'h5A, 1'b1);
    wait_done("a55a");
    chk("a55a_F", 32'(F), 32'h00);
    chk("a55a_C2", 32'(C2), 32'd1);
    launch(8'h03, 8'h04, 1'b0);
    wait_done("b2b");
    chk("b2b_F", 32'(F), 32'h07);
    chk("b2b_C2", 32'(C2), 32'd0);
    tick();

    // Start during RUN is ignored.
    launch(8'h12, 8'h34, 1'b0);
    tick(); tick();
    A = 8'hFF; B = 8'hFF; C1 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    begin
      int n = 3;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      chk("ign_latency", 32'(n), 32'(W));
    end
    chk("ign_F", 32'(F), 32'h46);
    chk("ign_C2", 32'(C2), 32'd0);
    tick();

    // Reset aborts a running addition.
    launch(8'hF0, 8'h0F, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_F", 32'(F), 32'h00);
    chk("abort_C2", 32'(C2), 32'd0);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    chk("abort_F_after", 32'(F), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
